// File: rtl/fetch_unit_if.sv
// Fetch-stage bundle: execute redirect, instruction-memory request/response and
// decode-side instruction channel. fetch_unit is the master; memory/core side the slave.
interface fetch_unit_if #(
  parameter int XLEN = 32
);
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_target;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic [XLEN-3:0] mem_req_addr;
  logic            mem_rsp_valid;
  logic [31:0]     mem_rsp_data;
  logic            inst_valid;
  logic            inst_ready;
  logic [31:0]     inst_data;
  logic [XLEN-1:0] inst_pc;
  logic            fetch_fault;

  modport master (
    input  redirect_valid, redirect_target, mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
    output mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc, fetch_fault
  );

  modport slave (
    output redirect_valid, redirect_target, mem_req_ready, mem_rsp_valid, mem_rsp_data, inst_ready,
    input  mem_req_valid, mem_req_addr, inst_valid, inst_data, inst_pc, fetch_fault
  );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, keeps up to BUF_DEPTH reads in flight and
// buffers returned words with their PC. Define FETCH_MISALIGN_TRAP_EN for the HALT trap.
module fetch_unit #(
  parameter int              XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter int              BUF_DEPTH    = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fetch_unit_if.master bus
);
  localparam int          AW      = $clog2(BUF_DEPTH);
  localparam int          CW      = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(BUF_DEPTH);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    DRAIN
`ifdef FETCH_MISALIGN_TRAP_EN
    , HALT
`endif
  } state_t;

  state_t          state_reg, state_next;
  logic [XLEN-1:0] pc_reg, pc_next;
  logic [CW-1:0]   out_reg, out_next;
  logic [CW-1:0]   drop_reg, drop_next;
  logic [CW-1:0]   fcnt_reg, fcnt_next;
  logic [AW-1:0]   fwr_reg, frd_reg, qwr_reg, qrd_reg;

  logic [31:0]     fifo_data [BUF_DEPTH];
  logic [XLEN-1:0] fifo_pc   [BUF_DEPTH];
  logic [XLEN-1:0] pc_queue  [BUF_DEPTH];

  logic        redirect, rsp, issue_ok, issue, push, pop, head_valid;
  logic [CW:0] inflight;

  assign redirect   = bus.redirect_valid;
  assign rsp        = bus.mem_rsp_valid;
  assign head_valid = (fcnt_reg != '0);
  assign inflight   = {1'b0, fcnt_reg} + {1'b0, out_reg};
  assign issue_ok   = (state_reg == RUN || state_reg == DRAIN) && !redirect && (inflight < DEPTH_W);
  assign issue      = issue_ok && bus.mem_req_ready;
  assign pop        = head_valid && bus.inst_ready;
  // Responses owed to a redirected-away stream are discarded, as is any in the redirect cycle.
  assign push       = rsp && (drop_reg == '0) && !redirect;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_reg, fault_next;
  logic misaligned;
  assign misaligned = (bus.redirect_target[1:0] != 2'b00);
`else
  logic unused_target_lsbs;
  assign unused_target_lsbs = ^bus.redirect_target[1:0];
`endif

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    drop_next  = drop_reg;
    out_next   = out_reg + CW'(issue) - CW'(rsp);
    fcnt_next  = fcnt_reg + CW'(push) - CW'(pop);
`ifdef FETCH_MISALIGN_TRAP_EN
    fault_next = fault_reg;
`endif
    if (issue) pc_next = pc_reg + XLEN'(4);
    if (rsp && drop_reg != '0) drop_next = drop_reg - CW'(1);
    if (redirect) begin
      fcnt_next = '0;
      drop_next = out_reg - CW'(rsp);
      pc_next   = {bus.redirect_target[XLEN-1:2], 2'b00};
    end
    case (state_reg)
      BOOT:    state_next = RUN;
`ifdef FETCH_MISALIGN_TRAP_EN
      HALT:    state_next = HALT;
`endif
      default: state_next = (drop_next != '0) ? DRAIN : RUN;
    endcase
`ifdef FETCH_MISALIGN_TRAP_EN
    if (redirect) begin
      if (misaligned) begin
        pc_next    = bus.redirect_target;
        state_next = HALT;
        fault_next = 1'b1;
      end else begin
        fault_next = 1'b0;
        state_next = (drop_next != '0) ? DRAIN : RUN;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= BOOT;
      pc_reg    <= RESET_VECTOR;
      out_reg   <= '0;
      drop_reg  <= '0;
      fcnt_reg  <= '0;
      fwr_reg   <= '0;
      frd_reg   <= '0;
      qwr_reg   <= '0;
      qrd_reg   <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      pc_reg    <= pc_next;
      out_reg   <= out_next;
      drop_reg  <= drop_next;
      fcnt_reg  <= fcnt_next;
`ifdef FETCH_MISALIGN_TRAP_EN
      fault_reg <= fault_next;
`endif
      if (redirect) begin
        fwr_reg <= '0;
        frd_reg <= '0;
      end else begin
        if (push) fwr_reg <= fwr_reg + AW'(1);
        if (pop)  frd_reg <= frd_reg + AW'(1);
      end
      // The request-PC queue is never flushed: it tracks every in-flight read, dropped or not.
      if (issue) qwr_reg <= qwr_reg + AW'(1);
      if (rsp)   qrd_reg <= qrd_reg + AW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[fwr_reg] <= bus.mem_rsp_data;
      fifo_pc[fwr_reg]   <= pc_queue[qrd_reg];
    end
    if (issue) pc_queue[qwr_reg] <= pc_reg;
  end

  assign bus.mem_req_valid = issue_ok;
  assign bus.mem_req_addr  = pc_reg[XLEN-1:2];
  assign bus.inst_valid    = head_valid;
  assign bus.inst_data     = head_valid ? fifo_data[frd_reg] : '0;
  assign bus.inst_pc       = head_valid ? fifo_pc[frd_reg] : '0;
`ifdef FETCH_MISALIGN_TRAP_EN
  assign bus.fetch_fault   = fault_reg;
`else
  assign bus.fetch_fault   = 1'b0;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: random in-order memory model, decode-side
// scoreboard of the architectural fetch stream, plus directed corner scenarios.
module tb_fetch_unit;
  localparam int XLEN      = 32;
  localparam int BUF_DEPTH = 2;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fetch_unit_if #(.XLEN(XLEN)) bus ();

  fetch_unit #(.XLEN(XLEN), .RESET_VECTOR(32'h0), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  typedef struct { logic [31:0] pc; logic [31:0] data; } inst_t;
  typedef struct { logic [29:0] addr; int due; } req_t;

  int          total = 0, passed = 0;
  inst_t       exp_q[$];
  req_t        pend_q[$];
  logic [31:0] exp_pc;
  logic [29:0] req_exp;
  bit          halted = 1'b0, seen_zero = 1'b0;
  int          cyc = 0, req_count = 0, retired = 0, last_due = 0;
  int          ready_pct = 100, lat_min = 1, lat_max = 1;

  // Instruction memory contents: a fixed scramble of the word address.
  function automatic logic [31:0] mem_word(logic [29:0] a);
    return ({a, 2'b00} * 32'h9E3779B1) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endtask

  // Memory model: random ready, in-order responses after a random latency >= 1.
  initial begin
    bus.mem_req_ready = 1'b0;
    bus.mem_rsp_valid = 1'b0;
    bus.mem_rsp_data  = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      bus.mem_req_ready = (int'($urandom_range(99)) < ready_pct);
      if (pend_q.size() != 0 && pend_q[0].due <= cyc) begin
        bus.mem_rsp_valid = 1'b1;
        bus.mem_rsp_data  = mem_word(pend_q[0].addr);
        void'(pend_q.pop_front());
      end else begin
        bus.mem_rsp_valid = 1'b0;
        bus.mem_rsp_data  = $urandom;
      end
    end
  end

  // Monitor: compares every retired instruction and every accepted request.
  initial begin
    inst_t e;
    int    due;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        check("fetch_fault", {31'b0, bus.fetch_fault}, {31'b0, halted});
        if (bus.inst_valid && bus.inst_ready) begin
          if (exp_q.size() == 0) begin
            total++;
            $display("FAIL unexpected_inst: got pc %h expected no instruction (cycle %0d)", bus.inst_pc, cyc);
          end else begin
            e = exp_q.pop_front();
            check("inst_pc", bus.inst_pc, e.pc);
            check("inst_data", bus.inst_data, e.data);
            retired++;
            if (bus.inst_pc == 32'h0) seen_zero = 1'b1;
          end
        end
        if (bus.mem_req_valid) begin
          check("req_blocked", {31'b0, bus.redirect_valid || halted}, 32'h0);
          if (bus.mem_req_ready) begin
            check("req_addr", {2'b0, bus.mem_req_addr}, {2'b0, req_exp});
            due = cyc + int'($urandom_range(lat_max, lat_min));
            if (due <= last_due) due = last_due + 1;
            last_due = due;
            pend_q.push_back('{bus.mem_req_addr, due});
            req_exp++;
            req_count++;
            check("outstanding_limit", {31'b0, (pend_q.size() + int'(bus.mem_rsp_valid)) <= BUF_DEPTH}, 32'h1);
          end
        end
        if (bus.redirect_valid) req_exp = bus.redirect_target[31:2];
      end
    end
  end

  // One cycle of stimulus; applies the previous cycle's redirect to the reference stream.
  task automatic step();
    @(posedge clk); #2;
    if (bus.redirect_valid) begin
      bus.redirect_valid = 1'b0;
      exp_q.delete();
      exp_pc = {bus.redirect_target[31:2], 2'b00};
`ifdef FETCH_MISALIGN_TRAP_EN
      halted = (bus.redirect_target[1:0] != 2'b00);
`endif
    end
    while (!halted && exp_q.size() < 16) begin
      exp_q.push_back('{exp_pc, mem_word(exp_pc[31:2])});
      exp_pc += 32'd4;
    end
  endtask

  task automatic steps(int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic redirect(logic [31:0] t);
    bus.redirect_valid  = 1'b1;
    bus.redirect_target = t;
    $display("redirect to %h at cycle %0d (retired %0d)", t, cyc, retired);
  endtask

  initial begin
    int r0, rc0;
    bit hit;
    rst_n = 1'b0;
    bus.redirect_valid  = 1'b0;
    bus.redirect_target = '0;
    bus.inst_ready      = 1'b0;
    exp_pc  = 32'h0;
    req_exp = '0;
    #2;
    check("rst_mem_req_valid", {31'b0, bus.mem_req_valid}, 32'h0);
    check("rst_mem_req_addr", {2'b0, bus.mem_req_addr}, 32'h0);
    check("rst_inst_valid", {31'b0, bus.inst_valid}, 32'h0);
    check("rst_inst_pc", bus.inst_pc, 32'h0);
    check("rst_inst_data", bus.inst_data, 32'h0);
    check("rst_fetch_fault", {31'b0, bus.fetch_fault}, 32'h0);
    #10 rst_n = 1'b1;

    // Decode stalled: only BUF_DEPTH reads may be issued, head holds pc 0.
    steps(10);
    @(negedge clk);
    check("stall_req_count", req_count, BUF_DEPTH);
    check("stall_req_valid", {31'b0, bus.mem_req_valid}, 32'h0);
    check("stall_inst_valid", {31'b0, bus.inst_valid}, 32'h1);
    check("stall_inst_pc", bus.inst_pc, 32'h0);
    $display("stall phase done: %0d requests", req_count);

    // Free-running sequential fetch.
    step();
    bus.inst_ready = 1'b1;
    steps(30);
    check("stream_progress", {31'b0, retired >= 10}, 32'h1);
    $display("sequential phase done: retired %0d", retired);

    // Two reads in flight with latency 3, then redirect: both must be dropped.
    lat_min = 3; lat_max = 3;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      step();
      hit = (pend_q.size() == 2);
    end
    check("two_outstanding_reached", {31'b0, hit}, 32'h1);
    r0 = retired;
    redirect(32'h100);
    steps(30);
    check("after_redirect_progress", {31'b0, retired > r0}, 32'h1);

    // Redirect coinciding with a response and a pop.
    lat_min = 1; lat_max = 1;
    hit = 1'b0;
    for (int i = 0; i < 50 && !hit; i++) begin
      step();
      hit = bus.mem_rsp_valid && bus.inst_valid && bus.inst_ready;
    end
    check("rsp_pop_cycle_reached", {31'b0, hit}, 32'h1);
    r0 = retired;
    redirect(32'h400);
    step();
    @(negedge clk);
    check("redirect_pop_done", retired, r0 + 1);
    check("flushed_next_cycle", {31'b0, bus.inst_valid}, 32'h0);
    steps(20);

    // PC wrap.
    redirect(32'hFFFF_FFF8);
    step();
    seen_zero = 1'b0;
    steps(30);
    check("pc_wrapped_to_zero", {31'b0, seen_zero}, 32'h1);

    // Misaligned redirect.
    redirect(32'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
    step();
    rc0 = req_count;
    steps(12);
    @(negedge clk);
    check("halt_fault", {31'b0, bus.fetch_fault}, 32'h1);
    check("halt_no_requests", req_count, rc0);
    check("halt_no_inst", {31'b0, bus.inst_valid}, 32'h0);
    r0 = retired;
    redirect(32'h200);
    steps(30);
    check("resume_fault_clear", {31'b0, bus.fetch_fault}, 32'h0);
    check("resume_progress", {31'b0, retired > r0}, 32'h1);
`else
    step();
    rc0 = req_count;
    r0 = retired;
    steps(30);
    check("misaligned_no_fault", {31'b0, bus.fetch_fault}, 32'h0);
    check("misaligned_progress", {31'b0, retired > r0 && req_count > rc0}, 32'h1);
`endif

    // Randomised traffic.
    lat_min = 1; lat_max = 4; ready_pct = 60;
    r0 = retired;
    for (int i = 0; i < 800; i++) begin
      step();
      bus.inst_ready = (int'($urandom_range(99)) < 70);
      if (int'($urandom_range(99)) < 4) redirect($urandom & 32'hFFFF_FFFC);
    end
    check("random_progress", {31'b0, (retired - r0) > 50}, 32'h1);
    $display("random phase done: retired %0d requests %0d", retired - r0, req_count);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
